// File: rtl/matrix_compare.sv
// Compares a snapshot of a ROW x COLUMN byte matrix against a row-major vector stream.
// Optional first-mismatch logging is built when MATRIX_COMPARE_ERRLOG_EN is defined.
module matrix_compare #(
  parameter int ROW    = 4,
  parameter int COLUMN = 4,
  localparam int N  = ROW * COLUMN,
  localparam int CW = $clog2(N + 1),
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1,
  localparam int KW = (COLUMN > 1) ? $clog2(COLUMN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    mat_in [ROW][COLUMN],
  input  logic          start,
  input  logic          abort,
  input  logic          vec_valid,
  input  logic [7:0]    vec_data,
  output logic          vec_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] mismatch_count,
  output logic [RW-1:0] err_row,
  output logic [KW-1:0] err_col,
  output logic [7:0]    err_exp,
  output logic [7:0]    err_act,
  output logic          err_valid,
  output logic [1:0]    state_dbg
);

  // Handshake: a vector beat transfers on a rising edge where vec_valid && vec_ready;
  // vec_ready is high only in CMP and the source may hold or drop vec_valid freely.
  typedef enum logic [1:0] {IDLE, SNAP, CMP, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [KW-1:0]   c_q, c_d;
  logic [7:0]      snap_q [ROW][COLUMN];
  logic [7:0]      snap_d [ROW][COLUMN];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            beat, mis;

`ifdef MATRIX_COMPARE_ERRLOG_EN
  logic [RW-1:0]   err_row_q, err_row_d;
  logic [KW-1:0]   err_col_q, err_col_d;
  logic [7:0]      err_exp_q, err_exp_d;
  logic [7:0]      err_act_q, err_act_d;
  logic            err_valid_q, err_valid_d;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
`ifdef MATRIX_COMPARE_ERRLOG_EN
    err_row_d   = err_row_q;
    err_col_d   = err_col_q;
    err_exp_d   = err_exp_q;
    err_act_d   = err_act_q;
    err_valid_d = err_valid_q;
`endif
    beat = (state_q == CMP) && vec_valid && !abort;
    mis  = beat && (vec_data != snap_q[r_q][c_q]);

    case (state_q)
      IDLE: begin
        if (start) state_d = SNAP;
      end
      SNAP: begin
        snap_d  = mat_in;
        cnt_d   = '0;
        pass_d  = 1'b0;
        r_d     = '0;
        c_d     = '0;
`ifdef MATRIX_COMPARE_ERRLOG_EN
        err_valid_d = 1'b0;
`endif
        state_d = abort ? IDLE : CMP;
      end
      CMP: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = IDLE;
        end else if (beat) begin
          if (mis && (cnt_q != CW'(N))) cnt_d = cnt_q + CW'(1);
`ifdef MATRIX_COMPARE_ERRLOG_EN
          if (mis && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_row_d   = r_q;
            err_col_d   = c_q;
            err_exp_d   = vec_data;
            err_act_d   = snap_q[r_q][c_q];
          end
`endif
          if (c_q == KW'(COLUMN - 1)) begin
            c_d = '0;
            if (r_q == RW'(ROW - 1)) begin
              // Pass result is visible in the same cycle as the done pulse.
              pass_d  = (cnt_d == '0);
              state_d = DONE;
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + KW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      for (int i = 0; i < ROW; i++)
        for (int j = 0; j < COLUMN; j++)
          snap_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      snap_q  <= snap_d;
    end
  end

`ifdef MATRIX_COMPARE_ERRLOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_row_q   <= '0;
      err_col_q   <= '0;
      err_exp_q   <= '0;
      err_act_q   <= '0;
      err_valid_q <= 1'b0;
    end else begin
      err_row_q   <= err_row_d;
      err_col_q   <= err_col_d;
      err_exp_q   <= err_exp_d;
      err_act_q   <= err_act_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign err_row   = err_row_q;
  assign err_col   = err_col_q;
  assign err_exp   = err_exp_q;
  assign err_act   = err_act_q;
  assign err_valid = err_valid_q;
`else
  assign err_row   = '0;
  assign err_col   = '0;
  assign err_exp   = '0;
  assign err_act   = '0;
  assign err_valid = 1'b0;
`endif

  assign vec_ready      = (state_q == CMP);
  assign busy           = (state_q == SNAP) || (state_q == CMP);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign mismatch_count = cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_matrix_compare.sv
// Directed bench for matrix_compare (4x4): clean, mismatch, throttled, abort,
// start-while-busy with live matrix change, and mid-pass reset scenarios.
module tb_matrix_compare;

  logic       clk;
  logic       rst_n;
  logic [7:0] mat_in [4][4];
  logic       start, abort, vec_valid;
  logic [7:0] vec_data;
  logic       vec_ready, busy, done, pass, err_valid;
  logic [4:0] mismatch_count;
  logic [1:0] err_row, err_col;
  logic [7:0] err_exp, err_act;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_m [16];

  matrix_compare #(.ROW(4), .COLUMN(4)) dut (
    .clk(clk), .rst_n(rst_n), .mat_in(mat_in), .start(start), .abort(abort),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .err_row(err_row), .err_col(err_col), .err_exp(err_exp), .err_act(err_act),
    .err_valid(err_valid), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_mat(input logic [7:0] m [16]);
    for (int i = 0; i < 16; i++) mat_in[i / 4][i % 4] = m[i];
  endtask

  // Driver: start at cycle 0, stream v, return the cycle done was seen (-1 if none).
  task automatic run_pass(input logic [7:0] v [16], input bit toggle, input int abort_at,
                          input int rst_at, input bit poke, output int done_cyc);
    int cyc;
    int beats;
    bit phase;
    bit stop;
    done_cyc = -1; beats = 0; cyc = 1; phase = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!stop && cyc < 100) begin
      if (done) begin
        done_cyc = cyc;
        stop = 1'b1;
      end else if (abort_at >= 0 && beats == abort_at) begin
        vec_valid = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        stop = 1'b1;
      end else if (rst_at >= 0 && beats == rst_at) begin
        vec_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        stop = 1'b1;
      end else begin
        if (poke && cyc == 3)
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) mat_in[i][j] = 8'hFF;
        start = poke && (cyc == 5);
        vec_valid = (beats < 16) && vec_ready && (!toggle || phase);
        vec_data = vec_valid ? v[beats] : 8'h00;
        if (vec_ready) phase = ~phase;
        if (vec_valid) beats++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    vec_valid = 1'b0;
    vec_data = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; vec_valid = 1'b0; vec_data = 8'h00;
    load_mat(ref_m);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (vec_ready !== 1'b0) begin failures++; $display("FAIL reset_vec_ready got=%b exp=0", vec_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
    checks++; if (mismatch_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", mismatch_count); end
    checks++; if ({err_valid, err_row, err_col, err_exp, err_act} !== 21'd0) begin
      failures++; $display("FAIL reset_err got=%h exp=0", {err_valid, err_row, err_col, err_exp, err_act}); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_pass();
    int dc;
    run_pass(ref_m, 1'b0, -1, -1, 1'b0, dc);
    checks++; if (dc !== 18) begin failures++; $display("FAIL clean_done_cycle got=%0d exp=18", dc); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL clean_pass got=%b exp=1", pass); end
    checks++; if (mismatch_count !== 5'd0) begin failures++; $display("FAIL clean_count got=%0d exp=0", mismatch_count); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL clean_err_valid got=%b exp=0", err_valid); end
    @(posedge clk); #1;
    checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL clean_done_width got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_mismatch();
    int dc;
    logic [7:0] v [16];
    v = ref_m; v[5] = 8'h07; v[14] = 8'h00;
    run_pass(v, 1'b0, -1, -1, 1'b0, dc);
    checks++; if (dc !== 18) begin failures++; $display("FAIL mis_done_cycle got=%0d exp=18", dc); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL mis_pass got=%b exp=0", pass); end
    checks++; if (mismatch_count !== 5'd2) begin failures++; $display("FAIL mis_count got=%0d exp=2", mismatch_count); end
`ifdef MATRIX_COMPARE_ERRLOG_EN
    checks++; if ({err_valid, err_row, err_col, err_exp, err_act} !== {1'b1, 2'd1, 2'd1, 8'h07, 8'h02}) begin
      failures++; $display("FAIL mis_errlog got=%h exp=%h", {err_valid, err_row, err_col, err_exp, err_act},
                           {1'b1, 2'd1, 2'd1, 8'h07, 8'h02}); end
`else
    checks++; if ({err_valid, err_row, err_col, err_exp, err_act} !== 21'd0) begin
      failures++; $display("FAIL mis_errlog_off got=%h exp=0", {err_valid, err_row, err_col, err_exp, err_act}); end
`endif
    @(posedge clk); #1;
    checks++; if (mismatch_count !== 5'd2 || pass !== 1'b0) begin
      failures++; $display("FAIL mis_hold got=%0d/%b exp=2/0", mismatch_count, pass); end
  endtask

  task automatic test_toggle();
    int dc;
    run_pass(ref_m, 1'b1, -1, -1, 1'b0, dc);
    checks++; if (dc !== 34) begin failures++; $display("FAIL toggle_done_cycle got=%0d exp=34", dc); end
    checks++; if (pass !== 1'b1 || mismatch_count !== 5'd0) begin
      failures++; $display("FAIL toggle_result got=%b/%0d exp=1/0", pass, mismatch_count); end
  endtask

  task automatic test_abort();
    int dc;
    logic [7:0] v [16];
    v = ref_m; v[3] = 8'h55;
    run_pass(v, 1'b0, 7, -1, 1'b0, dc);
    checks++; if (dc !== -1 || done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0d/%b exp=-1/0", dc, done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL abort_pass got=%b exp=0", pass); end
    checks++; if (mismatch_count !== 5'd1) begin failures++; $display("FAIL abort_count got=%0d exp=1", mismatch_count); end
`ifdef MATRIX_COMPARE_ERRLOG_EN
    checks++; if ({err_valid, err_row, err_col, err_exp, err_act} !== {1'b1, 2'd0, 2'd3, 8'h55, 8'h01}) begin
      failures++; $display("FAIL abort_errlog got=%h exp=%h", {err_valid, err_row, err_col, err_exp, err_act},
                           {1'b1, 2'd0, 2'd3, 8'h55, 8'h01}); end
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b%b exp=00", done, busy); end
    run_pass(ref_m, 1'b0, -1, -1, 1'b0, dc);
    checks++; if (dc !== 18 || pass !== 1'b1 || mismatch_count !== 5'd0) begin
      failures++; $display("FAIL abort_recover got=%0d/%b/%0d exp=18/1/0", dc, pass, mismatch_count); end
  endtask

  task automatic test_back_to_back_start_and_mat_change();
    int dc;
    run_pass(ref_m, 1'b0, -1, -1, 1'b1, dc);
    checks++; if (dc !== 18) begin failures++; $display("FAIL snap_done_cycle got=%0d exp=18", dc); end
    checks++; if (pass !== 1'b1 || mismatch_count !== 5'd0) begin
      failures++; $display("FAIL snap_result got=%b/%0d exp=1/0", pass, mismatch_count); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_ignored got=%b exp=0", busy); end
    load_mat(ref_m);
  endtask

  task automatic test_reset_mid_pass();
    int dc;
    logic [7:0] v [16];
    v = ref_m; v[2] = 8'h77;
    run_pass(v, 1'b0, -1, 9, 1'b0, dc);
    checks++; if ({busy, vec_ready, done, pass} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_ctrl got=%b exp=0000", {busy, vec_ready, done, pass}); end
    checks++; if (mismatch_count !== 5'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", mismatch_count); end
    checks++; if ({err_valid, err_row, err_col, err_exp, err_act} !== 21'd0) begin
      failures++; $display("FAIL rst_mid_err got=%h exp=0", {err_valid, err_row, err_col, err_exp, err_act}); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b%b exp=00", done, busy); end
    run_pass(ref_m, 1'b0, -1, -1, 1'b0, dc);
    checks++; if (dc !== 18 || pass !== 1'b1 || mismatch_count !== 5'd0) begin
      failures++; $display("FAIL rst_mid_recover got=%0d/%b/%0d exp=18/1/0", dc, pass, mismatch_count); end
  endtask

  initial begin
    ref_m = '{8'h00, 8'h00, 8'h01, 8'h01,
              8'h01, 8'h02, 8'h03, 8'h01,
              8'h02, 8'h01, 8'h02, 8'h01,
              8'h01, 8'h02, 8'h03, 8'h01};
    test_reset();
    test_clean_pass();
    test_mismatch();
    test_toggle();
    test_abort();
    test_back_to_back_start_and_mat_change();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
